// File: rtl/scandoubler_mode_ctrl_pkg.sv
// Shared types and constants for the scandoubler mode controller.
//  - state_e : lock qualification FSM encoding
//  - cfg_t   : stored configuration bits of the ZXUNO register
//  - CNT_W / CNT_SAT : width and saturation value of the line/frame counters
package scandoubler_mode_ctrl_pkg;

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_SAT = 10'd1023;

    localparam int unsigned CFG_REQ_VGA = 0;
    localparam int unsigned CFG_NOSCAN  = 1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_e;

    typedef struct packed {
        logic noscan;
        logic req_vga;
    } cfg_t;

    // Increment that sticks at the saturation value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sync_line_meter.sv
// Measures the source line length from hsync falling edges.
//  clk, rst          : clock, synchronous active-high reset
//  hsync_ext_n       : source hsync, active low
//  hs_fall_c         : hsync falling edge seen this clk
//  line_good_c       : current hcnt is a plausible, stable line length
//  hsync_lost_c      : hcnt has saturated (no hsync for 1023 clks)
//  line_len          : last captured line length
module sync_line_meter #(
    parameter int unsigned HTOL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_ext_n,
    output logic       hs_fall_c,
    output logic       line_good_c,
    output logic       hsync_lost_c,
    output logic [9:0] line_len
);
    import scandoubler_mode_ctrl_pkg::*;

    localparam int unsigned DIFF_W = CNT_W + 1;
    localparam logic signed [DIFF_W-1:0] TOL = $signed(DIFF_W'(HTOL));

    logic             prev_hs_q, prev_hs_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] line_len_q, line_len_d;
    logic signed [DIFF_W-1:0] diff_c;
    logic             in_tol_c;

    // Edge detect, tolerance check against the previous line, counter update.
    always_comb begin
        prev_hs_d    = hsync_ext_n;
        hs_fall_c    = prev_hs_q & ~hsync_ext_n;
        hsync_lost_c = (hcnt_q == CNT_SAT);
        // Zero-extended operands keep the 11-bit difference free of wrap.
        diff_c       = $signed({1'b0, hcnt_q}) - $signed({1'b0, line_len_q});
        in_tol_c     = (diff_c <= TOL) && (diff_c >= -TOL);
        line_good_c  = ~hsync_lost_c & in_tol_c;
        hcnt_d       = sat_inc(hcnt_q);
        line_len_d   = line_len_q;
        if (hs_fall_c) begin
            hcnt_d     = CNT_W'(1);
            line_len_d = hcnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_hs_q  <= 1'b1;
            hcnt_q     <= '0;
            line_len_q <= '0;
        end else begin
            prev_hs_q  <= prev_hs_d;
            hcnt_q     <= hcnt_d;
            line_len_q <= line_len_d;
        end
    end

    assign line_len = line_len_q;

endmodule

// File: rtl/scandoubler_mode_ctrl.sv
// Scandoubler mode controller: lock qualification, frame line count and the
// ZXUNO configuration register. Mode outputs change only on vsync falling
// edges, except that losing lock drops enable_scandoubling at once.
//  clk, rst                   : clock, synchronous active-high reset
//  zxuno_addr/regwr/regrd/din : register access; dout/oe read data and enable
//  hsync_ext_n, vsync_ext_n   : source syncs, active low
//  enable_scandoubling        : 1 = VGA output
//  disable_scaneffect         : 1 = scanlines off
//  locked                     : source timing qualified
//  line_len, lines_per_frame  : last measured line length / lines per frame
module scandoubler_mode_ctrl #(
    parameter logic [7:0]  ZXUNOADDR  = 8'h0B,
    parameter int unsigned HTOL       = 4,
    parameter int unsigned LOCK_LINES = 16,
    parameter int unsigned LOSS_LINES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regwr,
    input  logic       zxuno_regrd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe,
    input  logic       hsync_ext_n,
    input  logic       vsync_ext_n,
    output logic       enable_scandoubling,
    output logic       disable_scaneffect,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] lines_per_frame
);
    import scandoubler_mode_ctrl_pkg::*;

    localparam int unsigned GOOD_W = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) : 1;
    localparam int unsigned BAD_W  = (LOSS_LINES > 1) ? $clog2(LOSS_LINES) : 1;

    logic hs_fall_c, line_good_c, hsync_lost_c;

    sync_line_meter #(
        .HTOL (HTOL)
    ) u_meter (
        .clk          (clk),
        .rst          (rst),
        .hsync_ext_n  (hsync_ext_n),
        .hs_fall_c    (hs_fall_c),
        .line_good_c  (line_good_c),
        .hsync_lost_c (hsync_lost_c),
        .line_len     (line_len)
    );

    state_e            state_q, state_d;
    logic [GOOD_W-1:0] goodcnt_q, goodcnt_d;
    logic [BAD_W-1:0]  badcnt_q, badcnt_d;
    logic              locked_q, locked_d;
    logic              prev_vs_q, prev_vs_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    logic [CNT_W-1:0]  lpf_q, lpf_d;
    cfg_t              cfg_q, cfg_d;
    logic              en_q, en_d;
    logic              dis_q, dis_d;
    logic              vs_fall_c, cfg_wr_c, leaving_lock_c;
    logic              unused_din_c;

    // Lock qualification FSM.
    always_comb begin
        state_d   = state_q;
        goodcnt_d = goodcnt_q;
        badcnt_d  = badcnt_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (hs_fall_c) begin
                    state_d   = ST_ACQUIRE;
                    goodcnt_d = '0;
                end
            end
            ST_ACQUIRE: begin
                if (hs_fall_c) begin
                    if (!line_good_c) begin
                        goodcnt_d = '0;
                    end else if (goodcnt_q == GOOD_W'(LOCK_LINES - 1)) begin
                        state_d  = ST_LOCKED;
                        badcnt_d = '0;
                    end else begin
                        goodcnt_d = goodcnt_q + GOOD_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                // A saturated line counter means hsync is gone: drop lock now.
                if (hsync_lost_c) begin
                    state_d = ST_UNLOCKED;
                end else if (hs_fall_c) begin
                    if (line_good_c) begin
                        badcnt_d = '0;
                    end else if (badcnt_q == BAD_W'(LOSS_LINES - 1)) begin
                        state_d = ST_UNLOCKED;
                    end else begin
                        badcnt_d = badcnt_q + BAD_W'(1);
                    end
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    // Register write, frame counter and frame-synchronous mode outputs.
    always_comb begin
        vs_fall_c      = prev_vs_q & ~vsync_ext_n;
        prev_vs_d      = vsync_ext_n;
        cfg_wr_c       = zxuno_regwr && (zxuno_addr == ZXUNOADDR);
        leaving_lock_c = (state_q == ST_LOCKED) && (state_d != ST_LOCKED);
        locked_d       = (state_d == ST_LOCKED);
        unused_din_c   = ^din[7:2];

        cfg_d = cfg_q;
        if (cfg_wr_c) begin
            cfg_d.req_vga = din[CFG_REQ_VGA];
            cfg_d.noscan  = din[CFG_NOSCAN];
        end

        // vsync wins over a coincident hsync edge.
        vcnt_d = vcnt_q;
        lpf_d  = lpf_q;
        if (vs_fall_c) begin
            lpf_d  = vcnt_q;
            vcnt_d = '0;
        end else if (hs_fall_c) begin
            vcnt_d = sat_inc(vcnt_q);
        end

        // cfg_d so that a write in the vsync clk is already honoured.
        en_d  = en_q;
        dis_d = dis_q;
        if (vs_fall_c) begin
            en_d  = cfg_d.req_vga & locked_q;
            dis_d = cfg_d.noscan;
        end
        if (leaving_lock_c) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_UNLOCKED;
            goodcnt_q <= '0;
            badcnt_q  <= '0;
            locked_q  <= 1'b0;
            prev_vs_q <= 1'b1;
            vcnt_q    <= '0;
            lpf_q     <= '0;
            cfg_q     <= '0;
            en_q      <= 1'b0;
            dis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            goodcnt_q <= goodcnt_d;
            badcnt_q  <= badcnt_d;
            locked_q  <= locked_d;
            prev_vs_q <= prev_vs_d;
            vcnt_q    <= vcnt_d;
            lpf_q     <= lpf_d;
            cfg_q     <= cfg_d;
            en_q      <= en_d;
            dis_q     <= dis_d;
        end
    end

    // Combinational read port.
    assign oe   = zxuno_regrd && (zxuno_addr == ZXUNOADDR);
    assign dout = oe ? {locked_q, 5'b0, cfg_q.noscan, cfg_q.req_vga} : 8'h00;

    assign enable_scandoubling = en_q;
    assign disable_scaneffect  = dis_q;
    assign locked              = locked_q;
    assign lines_per_frame     = lpf_q;

endmodule

// File: tb/tb_scandoubler_mode_ctrl.sv
// Self-checking bench for scandoubler_mode_ctrl.
module tb_scandoubler_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] zxuno_addr;
    logic       zxuno_regwr;
    logic       zxuno_regrd;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe;
    logic       hsync_ext_n;
    logic       vsync_ext_n;
    logic       enable_scandoubling;
    logic       disable_scaneffect;
    logic       locked;
    logic [9:0] line_len;
    logic [9:0] lines_per_frame;

    scandoubler_mode_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .zxuno_addr          (zxuno_addr),
        .zxuno_regwr         (zxuno_regwr),
        .zxuno_regrd         (zxuno_regrd),
        .din                 (din),
        .dout                (dout),
        .oe                  (oe),
        .hsync_ext_n         (hsync_ext_n),
        .vsync_ext_n         (vsync_ext_n),
        .enable_scandoubling (enable_scandoubling),
        .disable_scaneffect  (disable_scaneffect),
        .locked              (locked),
        .line_len            (line_len),
        .lines_per_frame     (lines_per_frame)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic [7:0] exp_dout;
        logic       exp_oe;
    } reg_vec_t;

    int checks   = 0;
    int failures = 0;
    int prev_len = -1;   // period of the line started by the last hsync fall
    int vmodel   = 0;    // hsync falls since the last vsync fall (or reset)
    int len_q[$];
    int lpf_q[$];
    reg_vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // One source line of 'period' clks starting with an hsync fall.
    // vs_at >= 0 drops vsync at that clk of the line. echk/eexp check the
    // lock transition at this line's hsync fall: {pre_lk, pre_en, post_lk, post_en}.
    // vchk/vexp check the vsync update: {pre_en, post_en, pre_dis, post_dis}.
    task automatic line(input int period, input int vs_at,
                        input bit echk, input logic [3:0] eexp,
                        input bit vchk, input logic [3:0] vexp);
        int lo;
        lo = (period >= 256) ? 64 : period / 4;
        for (int i = 0; i < period; i++) begin
            @(negedge clk);
            if (i == 0) begin
                hsync_ext_n = 1'b0;
                if (prev_len >= 0) len_q.push_back((prev_len > 1023) ? 1023 : prev_len);
                prev_len = period;
                if (vs_at != 0) vmodel = (vmodel >= 1023) ? 1023 : vmodel + 1;
            end else if (i == lo) begin
                hsync_ext_n = 1'b1;
            end
            if (vs_at >= 0 && i == vs_at) begin
                vsync_ext_n = 1'b0;
                lpf_q.push_back(vmodel);
                vmodel = 0;
            end
            if (vs_at >= 0 && i == vs_at + 8) vsync_ext_n = 1'b1;
            #1;
            if (echk && i == 0) begin
                chk("lock_edge_pre_locked", int'(locked), int'(eexp[3]));
                chk("lock_edge_pre_enable", int'(enable_scandoubling), int'(eexp[2]));
            end
            if (i == 1) begin
                if (echk) begin
                    chk("lock_edge_post_locked", int'(locked), int'(eexp[1]));
                    chk("lock_edge_post_enable", int'(enable_scandoubling), int'(eexp[0]));
                end
                if (len_q.size() > 0) chk("line_len", int'(line_len), len_q.pop_front());
            end
            if (vchk && vs_at >= 0 && i == vs_at) begin
                chk("vs_pre_enable", int'(enable_scandoubling), int'(vexp[3]));
                chk("vs_pre_noscan", int'(disable_scaneffect), int'(vexp[1]));
            end
            if (vs_at >= 0 && i == vs_at + 1) begin
                if (lpf_q.size() > 0) chk("lines_per_frame", int'(lines_per_frame), lpf_q.pop_front());
                if (vchk) begin
                    chk("vs_post_enable", int'(enable_scandoubling), int'(vexp[2]));
                    chk("vs_post_noscan", int'(disable_scaneffect), int'(vexp[0]));
                end
            end
        end
    endtask

    task automatic lines(input int n, input int period);
        for (int k = 0; k < n; k++) line(period, -1, 1'b0, 4'h0, 1'b0, 4'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // addr, wr, rd, wdata, exp_dout, exp_oe  (applied while locked)
        vecs[0]  = '{8'h0B, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0};
        vecs[1]  = '{8'h0B, 1'b0, 1'b1, 8'h00, 8'h83, 1'b1};
        vecs[2]  = '{8'h0C, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[3]  = '{8'h0C, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{8'h0B, 1'b0, 1'b1, 8'h00, 8'h83, 1'b1};
        vecs[5]  = '{8'h0B, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0};
        vecs[6]  = '{8'h0B, 1'b1, 1'b1, 8'h01, 8'h82, 1'b1};
        vecs[7]  = '{8'h0B, 1'b0, 1'b1, 8'h00, 8'h81, 1'b1};
        vecs[8]  = '{8'h0B, 1'b1, 1'b1, 8'hFE, 8'h81, 1'b1};
        vecs[9]  = '{8'h0B, 1'b0, 1'b1, 8'h00, 8'h82, 1'b1};
        vecs[10] = '{8'h0B, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0};
        vecs[11] = '{8'h0B, 1'b0, 1'b1, 8'h00, 8'h83, 1'b1};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[13] = '{8'h0B, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};

        rst = 1'b1; zxuno_addr = 8'h00; zxuno_regwr = 1'b0; zxuno_regrd = 1'b0;
        din = 8'h00; hsync_ext_n = 1'b1; vsync_ext_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_enable", int'(enable_scandoubling), 0);
        chk("rst_noscan", int'(disable_scaneffect), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_line_len", int'(line_len), 0);
        chk("rst_lpf", int'(lines_per_frame), 0);
        chk("rst_oe", int'(oe), 0);

        // Acquire: 10 lines of 896.
        lines(10, 896);
        chk("acq_locked", int'(locked), 0);
        chk("acq_enable", int'(enable_scandoubling), 0);

        // 16 more lines; the 2nd fall is bad, falls 3..18 good -> lock at fall 18.
        for (int n = 11; n <= 26; n++)
            line(896, -1, n == 18, 4'b0010, 1'b0, 4'h0);
        chk("lock_after_26", int'(locked), 1);

        // Register table runs alongside a line, ending with cfg = 03.
        fork
            line(896, -1, 1'b0, 4'h0, 1'b0, 4'h0);
            begin
                foreach (vecs[k]) begin
                    @(negedge clk);
                    zxuno_addr = vecs[k].addr; zxuno_regwr = vecs[k].wr;
                    zxuno_regrd = vecs[k].rd; din = vecs[k].wdata;
                    #1;
                    chk($sformatf("reg_oe_%0d", k), int'(oe), int'(vecs[k].exp_oe));
                    if (vecs[k].exp_oe) chk($sformatf("reg_dout_%0d", k), int'(dout), int'(vecs[k].exp_dout));
                end
                @(negedge clk);
                zxuno_regwr = 1'b0; zxuno_regrd = 1'b0; zxuno_addr = 8'h00; din = 8'h00;
            end
        join
        // vsync applies the mode exactly one clk after the edge.
        line(896, 100, 1'b0, 4'h0, 1'b1, 4'b0101);

        // One odd line gives two bad comparisons: stays locked.
        line(905, -1, 1'b0, 4'h0, 1'b0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            line(896, -1, 1'b0, 4'h0, 1'b0, 4'h0);
            chk("one_odd_line_locked", int'(locked), 1);
        end
        // Alternating periods: four consecutive bad lines drop lock.
        line(905, -1, 1'b0, 4'h0, 1'b0, 4'h0);
        line(896, -1, 1'b0, 4'h0, 1'b0, 4'h0);
        line(905, -1, 1'b0, 4'h0, 1'b0, 4'h0);
        line(896, -1, 1'b0, 4'h0, 1'b0, 4'h0);
        line(200, -1, 1'b1, 4'b1100, 1'b0, 4'h0);

        // Re-lock at 200 clks/line, then enable on vsync.
        lines(18, 200);
        chk("relock1_locked", int'(locked), 1);
        line(200, 50, 1'b0, 4'h0, 1'b1, 4'b0111);

        // Reset pulse mid-frame while enabled.
        fork
            line(200, -1, 1'b0, 4'h0, 1'b0, 4'h0);
            begin
                repeat (100) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                prev_len = -1;
                vmodel = 0;
                #1;
                chk("midrst_enable", int'(enable_scandoubling), 0);
                chk("midrst_noscan", int'(disable_scaneffect), 0);
                chk("midrst_locked", int'(locked), 0);
                chk("midrst_line_len", int'(line_len), 0);
                chk("midrst_lpf", int'(lines_per_frame), 0);
                @(negedge clk);
                zxuno_addr = 8'h0B; zxuno_regrd = 1'b1;
                #1;
                chk("midrst_oe", int'(oe), 1);
                chk("midrst_cfg", int'(dout), 8'h00);
                @(negedge clk);
                zxuno_regrd = 1'b0; zxuno_addr = 8'h00;
            end
        join
        lines(19, 200);
        chk("relock2_locked", int'(locked), 1);
        // Locked but cfg cleared: vsync must not re-enable.
        line(200, 50, 1'b0, 4'h0, 1'b1, 4'b0000);
        fork
            line(200, -1, 1'b0, 4'h0, 1'b0, 4'h0);
            begin
                @(negedge clk);
                zxuno_addr = 8'h0B; zxuno_regwr = 1'b1; din = 8'h03;
                @(negedge clk);
                zxuno_regwr = 1'b0; zxuno_addr = 8'h00; din = 8'h00;
            end
        join
        line(200, 50, 1'b0, 4'h0, 1'b1, 4'b0101);

        // hsync held high: lock drops the clk after hcnt reaches 1023.
        fork
            line(1300, -1, 1'b0, 4'h0, 1'b0, 4'h0);
            begin
                repeat (1024) @(negedge clk);
                #1;
                chk("hold_locked_at_1023", int'(locked), 1);
                @(negedge clk);
                #1;
                chk("hold_locked_after", int'(locked), 0);
                chk("hold_enable_after", int'(enable_scandoubling), 0);
            end
        join

        // Frames of 313 hsync periods with vsync on an hsync edge:
        // the coincident edge is not counted, leaving 312 lines.
        fork
            line(16, 0, 1'b0, 4'h0, 1'b0, 4'h0);
            begin
                @(negedge clk);
                zxuno_addr = 8'h0B; zxuno_regrd = 1'b1;
                #1;
                chk("lost_oe", int'(oe), 1);
                chk("lost_dout", int'(dout), 8'h03);
                @(negedge clk);
                zxuno_regrd = 1'b0; zxuno_addr = 8'h00;
            end
        join
        for (int f = 0; f < 2; f++) begin
            lines(312, 16);
            line(16, 0, 1'b0, 4'h0, 1'b0, 4'h0);
            chk("lpf_312", int'(lines_per_frame), 312);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
